servo_pwm_multi: RTL



---
 rtl/servo_pwm_multi.sv | 135 +++++++++++++
 1 files changed

// File: rtl/servo_pwm_multi.sv
// rtl/servo_pwm_multi.sv - multi-channel servo PWM generator
// Samples pass hysteresis, moving average and clamped scaling into a shadow width loaded at period start.
module servo_pwm_multi #(
  parameter int CHANNELS      = 2,
  parameter int ANGLE_W       = 8,
  parameter int PERIOD_CYCLES = 1_000_000,
  parameter int CENTER        = 75_000,
  parameter int MIN_PULSE     = 25_000,
  parameter int MAX_PULSE     = 125_000,
  parameter int STEP          = 390,
  parameter int AVG_LOG2      = 4,
  parameter int HYST          = 1,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CW-1:0]       in_chan,
  input  logic [ANGLE_W-1:0]  in_mag,
  input  logic                in_neg,
  input  logic [CHANNELS-1:0] chan_en,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start,
  output logic                err_chan
);
  localparam int AW    = ANGLE_W + 1;
  localparam int SW    = AW + AVG_LOG2;
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int TMAX  = (PERIOD_CYCLES > MAX_PULSE + 1) ? PERIOD_CYCLES : MAX_PULSE + 1;
  localparam int TW    = $clog2(TMAX);

  typedef enum logic [1:0] {IDLE, UPD, SCALE} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]        chan_q;
  logic signed [AW-1:0] ang_q;
  logic                 err_q;
  logic signed [AW-1:0] filt_q   [CHANNELS];
  logic signed [AW-1:0] hist_q   [CHANNELS][DEPTH];
  logic signed [SW-1:0] sum_q    [CHANNELS];
  logic [TW-1:0]        shadow_q [CHANNELS];
  logic [TW-1:0]        active_q [CHANNELS];
  logic [TW-1:0]        counter_q;
  logic [CHANNELS-1:0]  pwm_q;
  logic                 pstart_q;

  logic                 accept;
  logic                 chan_ok;
  logic [CW-1:0]        idx;
  logic signed [AW:0]   diff;
  logic [AW:0]          diff_mag;
  logic signed [AW-1:0] filt_new;
  logic signed [SW-1:0] sum_new;
  logic signed [SW-1:0] avg;
  logic signed [31:0]   pulse;
  logic [TW-1:0]        pulse_clamped;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_d = UPD;
      end
      UPD:     state_d = SCALE;
      SCALE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Out-of-range samples still walk the FSM but are steered to channel 0 with writes gated off.
  assign chan_ok = int'(chan_q) < CHANNELS;
  assign idx     = chan_ok ? chan_q : '0;

  always_comb begin
    diff     = {ang_q[AW-1], ang_q} - {filt_q[idx][AW-1], filt_q[idx]};
    diff_mag = diff[AW] ? -diff : diff;
    filt_new = (int'(diff_mag) > HYST) ? ang_q : filt_q[idx];
    sum_new  = sum_q[idx] + SW'(filt_new) - SW'(hist_q[idx][DEPTH-1]);
    avg      = sum_q[idx] >>> AVG_LOG2;
    pulse    = CENTER + 32'(avg) * STEP;
    if (pulse < MIN_PULSE)      pulse_clamped = TW'(MIN_PULSE);
    else if (pulse > MAX_PULSE) pulse_clamped = TW'(MAX_PULSE);
    else                        pulse_clamped = pulse[TW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      chan_q    <= '0;
      ang_q     <= '0;
      err_q     <= 1'b0;
      counter_q <= '0;
      pwm_q     <= '0;
      pstart_q  <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        filt_q[c]   <= '0;
        sum_q[c]    <= '0;
        shadow_q[c] <= TW'(CENTER);
        active_q[c] <= TW'(CENTER);
        for (int k = 0; k < DEPTH; k++) hist_q[c][k] <= '0;
      end
    end else begin
      state_q <= state_d;
      err_q   <= accept && (int'(in_chan) >= CHANNELS);
      if (accept) begin
        chan_q <= in_chan;
        ang_q  <= in_neg ? -$signed({1'b0, in_mag}) : $signed({1'b0, in_mag});
      end
      if (state_q == UPD && chan_ok) begin
        filt_q[idx]    <= filt_new;
        sum_q[idx]     <= sum_new;
        hist_q[idx][0] <= filt_new;
        for (int k = 1; k < DEPTH; k++) hist_q[idx][k] <= hist_q[idx][k-1];
      end
      if (state_q == SCALE && chan_ok) shadow_q[idx] <= pulse_clamped;

      counter_q <= (counter_q == TW'(PERIOD_CYCLES - 1)) ? '0 : counter_q + 1'b1;
      pstart_q  <= (counter_q == '0);
      // At counter 0 compare against the width being loaded so the first cycle uses the new period's value.
      for (int c = 0; c < CHANNELS; c++) begin
        if (counter_q == '0) active_q[c] <= shadow_q[c];
        pwm_q[c] <= chan_en[c] && (counter_q < ((counter_q == '0) ? shadow_q[c] : active_q[c]));
      end
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = pstart_q;
  assign err_chan     = err_q;
endmodule
